// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter for the 16-bit I/O register bus.
// Serves one transaction at a time: IDLE grants, ACCESS drives the decoded target,
// RESP returns a one-cycle ack with read data and error status.
module io_bus_arbiter #(
   parameter int unsigned TIMEOUT = 16,  // ready wait limit in ACCESS cycles, >= 1
   parameter int unsigned TW      = 5    // counter width, 2**TW > TIMEOUT
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [1:0]  m_req_i,
   input  logic [1:0]  m_we_i,
   input  logic [15:0] m0_addr_i,
   input  logic [15:0] m1_addr_i,
   input  logic [15:0] m0_wdata_i,
   input  logic [15:0] m1_wdata_i,
   output logic [1:0]  m_ack_o,
   output logic        m_err_o,
   output logic [15:0] m_rdata_o,
   output logic        pio_sel_o,
   output logic        usb_sel_o,
   output logic        t_we_o,
   output logic [15:0] t_addr_o,
   output logic [15:0] t_wdata_o,
   input  logic [15:0] pio_rdata_i,
   input  logic [15:0] usb_rdata_i,
   input  logic        pio_ready_i,
   input  logic        usb_ready_i
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e        state_q, state_d;
   logic          grant_q, grant_d;
   logic          rr_q, rr_d;
   logic          we_q, we_d;
   logic          err_q, err_d;
   logic [15:0]   addr_q, addr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic [15:0]   rdata_q, rdata_d;
   logic [TW-1:0] cnt_q, cnt_d;

   logic          pio_hit, usb_hit, dec_err;
   logic          tgt_ready;
   logic [15:0]   tgt_rdata;
   logic [TW-1:0] cnt_inc;
   logic          win;

   // Address decode of the captured transaction; the two regions never overlap.
   always_comb begin
      pio_hit   = (addr_q[15:8] == 8'h40);
      usb_hit   = (addr_q[15:9] == 7'b0101000);
      dec_err   = addr_q[0] | ~(pio_hit | usb_hit);
      tgt_ready = pio_hit ? pio_ready_i : usb_ready_i;
      tgt_rdata = pio_hit ? pio_rdata_i : usb_rdata_i;
      cnt_inc   = cnt_q + TW'(1);
   end

   // Next-state logic: arbitration, target wait/timeout handling, pointer update.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      we_d    = we_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      win     = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (m_req_i != 2'b00) begin
               win     = (m_req_i == 2'b11) ? rr_q : m_req_i[1];
               grant_d = win;
               addr_d  = win ? m1_addr_i : m0_addr_i;
               wdata_d = win ? m1_wdata_i : m0_wdata_i;
               we_d    = m_we_i[win];
               state_d = StAccess;
            end
         end
         StAccess: begin
            if (dec_err) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = StResp;
            end else if (tgt_ready) begin
               err_d   = 1'b0;
               rdata_d = we_q ? 16'h0000 : tgt_rdata;
               state_d = StResp;
            end else if (cnt_inc == TW'(TIMEOUT)) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = StResp;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StResp: begin
            rr_d    = ~grant_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State register with synchronous active-low reset; a reset drops any transaction.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         grant_q <= 1'b0;
         rr_q    <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         we_q    <= we_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decoded from state and captured values; everything is zero outside its phase.
   always_comb begin
      m_ack_o   = 2'b00;
      m_err_o   = 1'b0;
      m_rdata_o = '0;
      pio_sel_o = 1'b0;
      usb_sel_o = 1'b0;
      t_we_o    = 1'b0;
      t_addr_o  = '0;
      t_wdata_o = '0;
      if (state_q == StAccess && !dec_err) begin
         pio_sel_o = pio_hit;
         usb_sel_o = usb_hit;
         t_we_o    = we_q;
         t_addr_o  = addr_q;
         t_wdata_o = wdata_q;
      end
      if (state_q == StResp) begin
         m_ack_o   = grant_q ? 2'b10 : 2'b01;
         m_err_o   = err_q;
         m_rdata_o = rdata_q;
      end
   end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single 16-bit I/O register bus between two masters: the CPU (master 0) and the USB endpoint DMA engine (master 1).
- Arbitrates between them round-robin and runs one transaction at a time.
- Decodes the address into the PIO region (LEDs, HEX, KEY, SW at 0x40xx) or the USB register region (0x5000–0x51FF).
- Handles target wait states, and flags unmapped, misaligned or timed-out accesses with an error response.

Parameters:
- TIMEOUT, 16, max cycles the arbiter waits for target ready after select; must be ≥1.
- TW, 5, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  synchronous reset, active-low
- m_req  in  2  per-master request; held until that master's ack
- m_we  in  2  per-master write enable (1 = write)
- m0_addr, m1_addr  in  16 each  byte address
- m0_wdata, m1_wdata  in  16 each  write data
- m_ack  out  2  one-cycle completion pulse per master
- m_err  out  1  error flag, valid only with an m_ack bit
- m_rdata  out  16  read data, valid with m_ack
- pio_sel  out  1  PIO region select
- usb_sel  out  1  USB region select
- t_we  out  1  target write enable
- t_addr  out  16  target address
- t_wdata  out  16  target write data
- pio_rdata, usb_rdata  in  16 each  target read data, sampled when ready
- pio_ready, usb_ready  in  1 each  target completion, same cycle as data

Behaviour:
- Reset (rst_n low at a clock edge):
  - state goes to IDLE; rr pointer set to 0 (master 0 has priority next).
  - all outputs go to 0: m_ack, m_err, m_rdata, pio_sel, usb_sel, t_we, t_addr, t_wdata.
  - the timeout counter clears.
  - reset mid-transaction abandons it silently; no ack is issued.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - if any m_req bit is high, grant a master. If both are high, grant the rr-pointer master; otherwise grant the single requester.
  - register the grant index and the winner's addr, we and wdata; go to ACCESS.
- Decode (applied to the registered address):
  - PIO hit: addr[15:8] = 0x40.
  - USB hit: addr[15:9] = 7'b0101000.
  - error if addr[0] = 1 or neither region hits.
- ACCESS:
  - error decode: no select is asserted; go to RESP with err = 1 and rdata = 0.
  - valid decode: assert the matching select plus t_we, t_addr and t_wdata (all registered, stable through ACCESS).
  - matching ready high: capture the matching rdata (0 for writes) and go to RESP with err = 0.
  - the non-selected target's ready is ignored.
  - the counter increments each ACCESS cycle without ready. When the count reaches TIMEOUT, go to RESP with err = 1 and rdata = 0.
- RESP:
  - selects are deasserted; m_ack[grant] is high for exactly one cycle with m_rdata and m_err.
  - rr pointer becomes ~grant; go to IDLE.
- Latency and throughput:
  - req sampled in IDLE at edge N; select high in cycle N+1.
  - with zero wait states, ack is high in cycle N+2.
  - a back-to-back transaction takes 3 cycles minimum, because IDLE always lasts one cycle.
- Master rules:
  - a master drops req in the cycle after its ack, or keeps it high to request again.
  - a req still high in the IDLE cycle after an ack is treated as a new request.
  - changing addr, we or wdata while req is high before ack is ignored, since values are captured at grant.
- Fairness: under continuous requests from both masters, grants alternate 0,1,0,1; neither master waits more than one transaction.
- Only one select is ever high; pio_sel and usb_sel are never high together.

Test Plan:
- CPU read with zero wait states: m0 reads 0x4022 with pio_ready tied high and pio_rdata = 0x00A5. Required: pio_sel high 1 cycle, t_addr = 0x4022, m_ack = 2'b01 two cycles after req, m_rdata = 0x00A5, m_err = 0.
- USB write with wait states: m1 writes 0xBEEF to 0x5002; usb_ready rises after 3 wait cycles. Required: usb_sel high 4 cycles, t_we = 1, t_wdata = 0xBEEF throughout, m_ack = 2'b10, m_err = 0.
- Simultaneous requests: both masters request continuously from reset. Required: grant order 0,1,0,1; each ack separated by ≥3 cycles; rr pointer toggles each time.
- Bad addresses:
  - 0x6000 (unmapped) and 0x4001 (odd): no select asserted, ack with m_err = 1 and rdata = 0 two cycles after req.
  - 0x5100 (last region page): decodes to usb_sel.
- Timeout: PIO access with pio_ready held low and TIMEOUT = 16. Required: pio_sel high exactly 16 cycles, then ack with m_err = 1; the next request is served normally.
- Reset mid-access: rst_n low during ACCESS with a wait state pending. Required: all outputs 0 the next cycle, no ack; after release, m0 wins a simultaneous request.
